qcontrol_multitap: RTL and testbench
====================================

# qcontrol_multitap

Multi-tap Q-Control feedback mixer: a parametrised successor to the single-tap delay/gain Q-Control stage in the RPSPMC PAC-PLL path. It decimates the incoming amplitude/phase-corrected signal and stores it in a circular delay line. Per output sample it sums NTAPS independently delayed and gain-weighted copies, computed by a time-multiplexed MAC, then saturates the result. The output is an AXIS-style stream feeding the excitation volume mixer.

## Interface
- SIGNAL_M_WIDTH, 16, signed input sample width
- OUT_WIDTH, 16, signed output width
- GAIN_WIDTH, 16, signed per-tap gain width
- GAIN_Q, 14, gain fraction bits (0x4000 = 1.0)
- QC_PHASE_LEN2, 13, log2 of delay line depth
- NTAPS, 4, number of taps (1..16)
- DECII, 8, a_clk cycles per sample tick; must be ≥ NTAPS+4

Ports:
- a_clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- S_AXIS_SIGNAL_M_tdata  in  SIGNAL_M_WIDTH  signed input sample
- S_AXIS_SIGNAL_M_tvalid  in  1  input sample valid
- QC_enable  in  1  mixer enable
- QC_gain  in  NTAPS*GAIN_WIDTH  tap k gain at bits [k*GAIN_WIDTH +: GAIN_WIDTH], signed
- QC_delay  in  NTAPS*16  tap k delay in ticks at bits [k*16 +: 16]; only the low QC_PHASE_LEN2 bits are used
- M_AXIS_tdata  out  OUT_WIDTH  signed mixer output, held between updates
- M_AXIS_tvalid  out  1  one-cycle pulse per new output
- QC_sat  out  1  high for the same cycle as the tvalid pulse when that output saturated

## Operation
- **Tick counter:** free-running decimation counter cnt, 0..DECII-1. A tick occurs when cnt==DECII-1 and S_AXIS_SIGNAL_M_tvalid==1. If tvalid is low at cnt==DECII-1, no tick occurs, nothing is written and no output is produced.
- **Latching at tick:** sample, QC_enable, QC_gain and QC_delay are latched. Config changes between ticks have no effect.
- **State machine:** IDLE → WRITE → MAC → OUT → IDLE.
  - WRITE (1 cycle): delayline[wp] ← sample; n ← min(n+1, 2^QC_PHASE_LEN2); the written address is kept as wa; wp ← wp+1 (mod depth).
  - MAC (NTAPS+1 cycles): synchronous reads at address wa − d_k (mod depth) for k=0..NTAPS-1, one per cycle. The product gain_k·x (full GAIN_WIDTH+SIGNAL_M_WIDTH bits) is accumulated one cycle after each read returns.
  - OUT (1 cycle): register the output, pulse tvalid.
- **Delay semantics:** d=0 returns the sample written in the same tick. d=k returns the sample from k ticks earlier.
- **Unfilled taps:** a tap with d ≥ n contributes 0. n counts samples written since reset, including the current one. Stale memory contents are therefore never used.
- **Arithmetic:** accumulator width is GAIN_WIDTH+SIGNAL_M_WIDTH+clog2(NTAPS), so no internal overflow is possible. Result = acc >>> GAIN_Q (arithmetic shift, floor), then saturated to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]. QC_sat=1 when clipping occurred.
- **Disabled mixer:** with latched enable=0, the output is 0 with QC_sat=0 and tvalid still pulses. The delay line and n still update.
- **Reset:** M_AXIS_tdata=0, M_AXIS_tvalid=0, QC_sat=0, cnt=0, wp=0, n=0, state=IDLE. Delay line RAM is not cleared. Reset during WRITE/MAC/OUT aborts the sample and no tvalid pulse is produced for it.

## Timing
- Tick at cycle T: WRITE at T+1, MAC at T+2..T+NTAPS+2, OUT at T+NTAPS+3.
- M_AXIS_tdata changes and M_AXIS_tvalid=1 at T+NTAPS+3; latency is NTAPS+3 cycles.
- Successive tvalid pulses are ≥ DECII cycles apart. A tick never arrives while busy because DECII ≥ NTAPS+4; check this with an elaboration-time assertion.
- The write→read ordering guarantees that d=0 reads the new sample (write at T+1, first read at T+2).
- Pointer wrap: wa−d is computed modulo 2^QC_PHASE_LEN2. Maximum delay is 2^QC_PHASE_LEN2−1.
- No output backpressure (no tready).

## Test plan
- **Impulse response:** NTAPS=4, tap0 gain 0x4000 with d=3, other gains 0. After ≥4 ticks of fill, drive a single 1000 then zeros → tdata=1000 exactly on the 4th pulse after the impulse, 0 on all other pulses, latency 7 cycles from tick.
- **Multi-tap sum:** gains 0x4000/0x2000/−0x4000/0 with delays 0/1/2/0. After ≥3 ticks of fill, drive a 400, 400, 400 ramp → third output = 400+200−400 = 200.
- **Saturation:** two taps, gain 0x7FFF, d=0, input 32767 → tdata=32767 with QC_sat=1. Input −32768 → tdata=−32768 with QC_sat=1.
- **Fill after reset:** one tap, gain 0x4000, d=10, constant input 500 → the first 10 outputs are 0, the 11th onward are 500. QC_delay=8191 with wrap across wp=0 returns the correct sample.
- **Gaps and enable:** tvalid low at cnt==7 → no pulse for that period and wp unchanged. QC_enable=0 → pulse with tdata=0. Re-enable → correct delayed data immediately, since history was kept.
- **Reset mid-MAC:** assert reset at T+3 → no pulse, all outputs 0. The first post-reset outputs follow fill rules with n=0.

Source files
------------

// File: rtl/qcontrol_multitap.sv
// qcontrol_multitap: decimated delay line with time-multiplexed multi-tap gain MAC and saturating stream output
module qcontrol_multitap #(
  parameter int SIGNAL_M_WIDTH = 16,
  parameter int OUT_WIDTH = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int GAIN_Q = 14,
  parameter int QC_PHASE_LEN2 = 13,
  parameter int NTAPS = 4,
  parameter int DECII = 8
) (
  input  logic a_clk,
  input  logic reset,
  input  logic [SIGNAL_M_WIDTH-1:0] S_AXIS_SIGNAL_M_tdata,
  input  logic S_AXIS_SIGNAL_M_tvalid,
  input  logic QC_enable,
  input  logic [NTAPS*GAIN_WIDTH-1:0] QC_gain,
  input  logic [NTAPS*16-1:0] QC_delay,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic M_AXIS_tvalid,
  output logic QC_sat
);
  localparam int L = QC_PHASE_LEN2;
  localparam int DEPTH = 1 << L;
  localparam int CW = $clog2(DECII);
  localparam int JW = $clog2(NTAPS + 1);
  localparam int TW = NTAPS > 1 ? $clog2(NTAPS) : 1;
  localparam int PW = GAIN_WIDTH + SIGNAL_M_WIDTH;
  localparam int AW = PW + $clog2(NTAPS);
  localparam logic signed [AW-1:0] MAXV = {{(AW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  if (DECII < NTAPS + 4 || NTAPS < 1 || NTAPS > 16) begin : g_bad_params
    $error("qcontrol_multitap: need 1 <= NTAPS <= 16 and DECII >= NTAPS+4");
  end
  typedef enum logic [1:0] {IDLE, WRITE, MAC, OUT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [L-1:0] wp, wa, ra;
  logic [L:0] n;
  logic [JW-1:0] j;
  logic [TW-1:0] jr, jp;
  logic signed [SIGNAL_M_WIDTH-1:0] x, rd;
  logic signed [SIGNAL_M_WIDTH-1:0] mem [DEPTH];
  logic en, tick, tap_ok, sat;
  logic signed [GAIN_WIDTH-1:0] gn [NTAPS];
  logic [L-1:0] dl [NTAPS];
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc, acc_next, sh;
  logic [OUT_WIDTH-1:0] outv;
  logic unused_delay;
  assign unused_delay = ^QC_delay;
  always_comb begin
    tick = cnt == CW'(DECII - 1) && S_AXIS_SIGNAL_M_tvalid;
    jr = int'(j) < NTAPS ? TW'(j) : '0;
    jp = TW'(j - 1'b1);
    ra = wa - dl[jr];
    tap_ok = j != '0 && {1'b0, dl[jp]} < n;
    prod = PW'(gn[jp]) * PW'(rd);
    acc_next = tap_ok ? acc + AW'(prod) : acc;
    sh = acc_next >>> GAIN_Q;
    sat = sh > MAXV || sh < MINV;
    outv = sat ? (sh[AW-1] ? MINV[OUT_WIDTH-1:0] : MAXV[OUT_WIDTH-1:0]) : sh[OUT_WIDTH-1:0];
  end
  always_ff @(posedge a_clk) begin
    if (!reset && state == WRITE) mem[wp] <= x;
    rd <= mem[ra];
  end
  always_ff @(posedge a_clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      wp <= '0;
      n <= '0;
      j <= '0;
      acc <= '0;
      M_AXIS_tdata <= '0;
      M_AXIS_tvalid <= 1'b0;
      QC_sat <= 1'b0;
    end else begin
      cnt <= cnt == CW'(DECII - 1) ? '0 : cnt + 1'b1;
      M_AXIS_tvalid <= 1'b0;
      QC_sat <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          x <= S_AXIS_SIGNAL_M_tdata;
          en <= QC_enable;
          for (int k = 0; k < NTAPS; k++) begin
            gn[k] <= QC_gain[k*GAIN_WIDTH +: GAIN_WIDTH];
            dl[k] <= QC_delay[k*16 +: L];
          end
          state <= WRITE;
        end
        WRITE: begin
          wa <= wp;
          wp <= wp + 1'b1;
          n <= n + (L+1)'(!n[L]);
          j <= '0;
          acc <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc_next;
          j <= j + 1'b1;
          if (int'(j) == NTAPS) begin
            M_AXIS_tvalid <= 1'b1;
            M_AXIS_tdata <= en ? outv : '0;
            QC_sat <= en & sat;
            state <= OUT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qcontrol_multitap.sv
// tb_qcontrol_multitap: directed self-checking bench for qcontrol_multitap
module tb_qcontrol_multitap;
  logic a_clk = 0, reset = 1;
  logic [15:0] s_tdata = '0;
  logic s_tvalid = 0, en = 1;
  logic [63:0] gain = '0, delay = '0;
  logic [15:0] m_tdata;
  logic m_tvalid, m_sat;
  logic [2:0] bc = '0;
  int nv = 0, nf = 0;
  qcontrol_multitap #(.QC_PHASE_LEN2(6)) dut (
    .a_clk(a_clk),
    .reset(reset),
    .S_AXIS_SIGNAL_M_tdata(s_tdata),
    .S_AXIS_SIGNAL_M_tvalid(s_tvalid),
    .QC_enable(en),
    .QC_gain(gain),
    .QC_delay(delay),
    .M_AXIS_tdata(m_tdata),
    .M_AXIS_tvalid(m_tvalid),
    .QC_sat(m_sat)
  );
  always #5 a_clk = ~a_clk;
  always @(posedge a_clk) bc <= reset ? 3'd0 : bc + 3'd1;
  task automatic set_tap(input int k, input logic [15:0] g, input logic [15:0] d);
    gain[k*16 +: 16] = g;
    delay[k*16 +: 16] = d;
  endtask
  task automatic do_reset();
    @(negedge a_clk);
    reset = 1;
    repeat (2) @(negedge a_clk);
    reset = 0;
  endtask
  task automatic do_tick(input logic [15:0] x, input logic [15:0] ev, input logic es, input string nm);
    while (bc != 3'd7) @(negedge a_clk);
    s_tdata = x;
    s_tvalid = 1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge a_clk);
      s_tvalid = 0;
      if (i == 6) begin
        nv++;
        if (m_tvalid !== 1'b0) begin nf++; $display("FAIL %s early_pulse: tvalid=%b required 0", nm, m_tvalid); end
      end
      if (i == 7) begin
        nv++;
        if (m_tvalid !== 1'b1) begin nf++; $display("FAIL %s tvalid: got %b required 1", nm, m_tvalid); end
        nv++;
        if (m_tdata !== ev) begin nf++; $display("FAIL %s tdata: got %0d required %0d", nm, $signed(m_tdata), $signed(ev)); end
        nv++;
        if (m_sat !== es) begin nf++; $display("FAIL %s sat: got %b required %b", nm, m_sat, es); end
      end
      if (i == 8) begin
        nv++;
        if (m_tvalid !== 1'b0) begin nf++; $display("FAIL %s pulse_width: tvalid=%b required 0", nm, m_tvalid); end
      end
    end
  endtask
  task automatic test_reset();
    do_reset();
    nv++;
    if (m_tvalid !== 1'b0) begin nf++; $display("FAIL reset_tvalid: got %b required 0", m_tvalid); end
    nv++;
    if (m_tdata !== 16'd0) begin nf++; $display("FAIL reset_tdata: got %0d required 0", m_tdata); end
    nv++;
    if (m_sat !== 1'b0) begin nf++; $display("FAIL reset_sat: got %b required 0", m_sat); end
  endtask
  task automatic test_impulse();
    gain = '0; delay = '0;
    set_tap(0, 16'h4000, 16'd3);
    for (int i = 0; i < 4; i++) do_tick(16'd0, 16'd0, 1'b0, "imp_fill");
    do_tick(16'd1000, 16'd0, 1'b0, "imp_p1");
    do_tick(16'd0, 16'd0, 1'b0, "imp_p2");
    do_tick(16'd0, 16'd0, 1'b0, "imp_p3");
    do_tick(16'd0, 16'd1000, 1'b0, "imp_p4");
    do_tick(16'd0, 16'd0, 1'b0, "imp_p5");
  endtask
  task automatic test_multitap();
    gain = '0; delay = '0;
    set_tap(0, 16'h4000, 16'd0);
    set_tap(1, 16'h2000, 16'd1);
    set_tap(2, 16'hC000, 16'd2);
    for (int i = 0; i < 3; i++) do_tick(16'd0, 16'd0, 1'b0, "mt_fill");
    do_tick(16'd400, 16'd400, 1'b0, "mt_r1");
    do_tick(16'd400, 16'd600, 1'b0, "mt_r2");
    do_tick(16'd400, 16'd200, 1'b0, "mt_r3");
  endtask
  task automatic test_saturation();
    gain = '0; delay = '0;
    set_tap(0, 16'h7FFF, 16'd0);
    set_tap(1, 16'h7FFF, 16'd0);
    do_tick(16'd32767, 16'h7FFF, 1'b1, "sat_pos");
    do_tick(16'h8000, 16'h8000, 1'b1, "sat_neg");
    do_tick(16'd100, 16'd399, 1'b0, "floor_pos");
    do_tick(-16'sd100, -16'sd400, 1'b0, "floor_neg");
  endtask
  task automatic test_fill_wrap();
    do_reset();
    gain = '0; delay = '0;
    set_tap(0, 16'h4000, 16'd10);
    for (int i = 0; i < 12; i++) do_tick(16'd500, i < 10 ? 16'd0 : 16'd500, 1'b0, "fill");
    do_reset();
    set_tap(0, 16'h4000, 16'd63);
    for (int k = 0; k < 70; k++) do_tick(16'(k*3+1), k >= 63 ? 16'((k-63)*3+1) : 16'd0, 1'b0, "wrap");
  endtask
  task automatic test_gaps_enable();
    logic seen;
    gain = '0; delay = '0;
    set_tap(0, 16'h4000, 16'd2);
    do_tick(16'd11, 16'd205, 1'b0, "ge_a");
    do_tick(16'd22, 16'd208, 1'b0, "ge_b");
    do_tick(16'd33, 16'd11, 1'b0, "ge_c");
    while (bc != 3'd7) @(negedge a_clk);
    s_tdata = 16'd99;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge a_clk);
      seen = seen | m_tvalid;
    end
    nv++;
    if (seen !== 1'b0) begin nf++; $display("FAIL gap_pulse: tvalid seen=%b required 0", seen); end
    do_tick(16'd44, 16'd22, 1'b0, "ge_after_gap");
    en = 0;
    do_tick(16'd55, 16'd0, 1'b0, "ge_disabled");
    en = 1;
    do_tick(16'd66, 16'd44, 1'b0, "ge_reenable");
    do_tick(16'd77, 16'd55, 1'b0, "ge_hist");
  endtask
  task automatic test_reset_mid_mac();
    logic seen;
    while (bc != 3'd7) @(negedge a_clk);
    s_tdata = 16'd999;
    s_tvalid = 1;
    @(negedge a_clk);
    s_tvalid = 0;
    @(negedge a_clk);
    @(negedge a_clk);
    reset = 1;
    @(negedge a_clk);
    nv++;
    if (m_tdata !== 16'd0) begin nf++; $display("FAIL midmac_tdata: got %0d required 0", m_tdata); end
    reset = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge a_clk);
      seen = seen | m_tvalid | m_sat;
    end
    nv++;
    if (seen !== 1'b0) begin nf++; $display("FAIL midmac_pulse: tvalid/sat seen=%b required 0", seen); end
    gain = '0; delay = '0;
    set_tap(0, 16'h4000, 16'd1);
    do_tick(16'd300, 16'd0, 1'b0, "midmac_fill");
    do_tick(16'd301, 16'd300, 1'b0, "midmac_first");
  endtask
  initial begin
    test_reset();
    test_impulse();
    test_multitap();
    test_saturation();
    test_fill_wrap();
    test_gaps_enable();
    test_reset_mid_mac();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
